// File: rtl/alu_pipe.sv
// alu_pipe: pipelined, valid/ready handshaked ALU with registered result and flags.
//
// Parameters:
//   WIDTH      operand/result width (power of two, >= 8)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands and op presented
//   in_ready   block can accept a new operation
//   A, B       operands (shift amount is the low log2(WIDTH) bits of B)
//   ALUOp      000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110 SLL, 111 MUL
//   out_valid  Result and flags hold a result not yet taken
//   out_ready  consumer accepts the result
//   Result     registered result
//   N, V, C, Z registered negative, overflow, carry and zero flags
//
// Build option:
//   ALU_MUL_EN  when defined, op 111 is an iterative shift-add multiply taking
//               WIDTH cycles; when undefined, op 111 is single-cycle and yields 0.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic             Z
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             write_result;
    logic [WIDTH-1:0] wr_result;
    logic             wr_c;
    logic             wr_v;

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_v;

    assign accept = in_valid & in_ready;

    // Single-cycle datapath. SUB and SLT share one adder fed with ~B and a
    // carry-in of 1; overflow is "operand signs agree but the sum's sign
    // differs", which with ~B folded in covers both ADD and SUB.
    always_comb begin
        is_sub     = (ALUOp == OP_SUB) || (ALUOp == OP_SLT);
        b_op       = is_sub ? ~B : B;
        sum        = {1'b0, A} + {1'b0, b_op} + (WIDTH + 1)'(is_sub);
        sum_ovf    = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (ALUOp)
            OP_AND: alu_result = A & B;
            OP_OR:  alu_result = A | B;
            OP_ADD, OP_SUB: begin
                alu_result = sum[WIDTH-1:0];
                alu_c      = sum[WIDTH];
                alu_v      = sum_ovf;
            end
            OP_XOR: alu_result = A ^ B;
            // Signed less-than is the difference's sign corrected by overflow.
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
            OP_SLL: alu_result = A << B[SW-1:0];
            default: alu_result = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               mul_last;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set. The final step's sum is the product itself.
    always_comb begin
        acc_step = acc + (mplier[0] ? mcand : '0);
        mul_last = (state == MUL_BUSY) && (cnt == CW'(WIDTH - 1));
    end

    // Multiplier registers are loaded on a MUL accept and stepped every
    // MUL_BUSY cycle; the counter wraps back to zero on the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && (ALUOp == OP_MUL)) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL_BUSY) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= mul_last ? '0 : cnt + CW'(1);
        end
    end

    // Result source: the multiplier on its completing step, otherwise the
    // single-cycle datapath on a non-MUL accept.
    always_comb begin
        write_result = (accept && (ALUOp != OP_MUL)) || mul_last;
        wr_result    = mul_last ? acc_step[WIDTH-1:0] : alu_result;
        wr_c         = mul_last ? 1'b0 : alu_c;
        wr_v         = mul_last ? (acc_step[2*WIDTH-1:WIDTH] != '0) : alu_v;
    end
`else
    // Without the multiplier every op, including 111, finishes in one cycle.
    always_comb begin
        write_result = accept;
        wr_result    = alu_result;
        wr_c         = alu_c;
        wr_v         = alu_v;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: only a MUL accept leaves IDLE.
    always_comb begin
        state_next = state;
        case (state)
`ifdef ALU_MUL_EN
            IDLE:     if (accept && (ALUOp == OP_MUL)) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_last) state_next = IDLE;
`endif
            default:  state_next = IDLE;
        endcase
    end

    // Output logic: accept only when idle and the output slot is free or
    // being drained on this edge.
    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready) && rst_n;
    end

    // Output registers. A write only happens when the slot is free or being
    // drained, so an untaken result is never overwritten.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Result    <= '0;
            N         <= 1'b0;
            V         <= 1'b0;
            C         <= 1'b0;
            Z         <= 1'b0;
        end else begin
            out_valid <= write_result || (out_valid && !out_ready);
            if (write_result) begin
                Result <= wr_result;
                N      <= wr_result[WIDTH-1];
                V      <= wr_v;
                C      <= wr_c;
                Z      <= (wr_result == '0);
            end
        end
    end

endmodule
